cpu_mem_bridge: RTL and testbench

Single-outstanding-request bridge between the 6502 core and the PSRAM memory controller, clocked on clkRAM. It accepts one CPU bus cycle at a time and forwards RAM accesses as one-byte transfers to the memory controller. It services the VIC register window ($D000–$D3FF) locally, including border and background colour registers for video. It stalls the CPU through `cpu_rdy` until each access completes and aborts hung transfers with a timeout.

---
 rtl/cpu_mem_bridge_if.sv | 35 +++
 rtl/cpu_mem_bridge.sv | 132 +++++++++++++
 tb/tb_cpu_mem_bridge.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_bridge_if.sv
// CPU-side and memory-controller-side handshake bundle for cpu_mem_bridge.
// The master modport is the bridge's view; the slave modport is the CPU/memory side.
interface cpu_mem_bridge_if;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned NB_W   = 4;

    logic              cpu_valid;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rdy;
    logic              cpu_done;

    logic              mem_ce;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [NB_W-1:0]   mem_nbytes;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_busy;

    modport master (
        input  cpu_valid, cpu_addr, cpu_we, cpu_wdata, mem_rdata, mem_busy,
        output cpu_rdata, cpu_rdy, cpu_done,
               mem_ce, mem_write, mem_addr, mem_nbytes, mem_wdata
    );

    modport slave (
        output cpu_valid, cpu_addr, cpu_we, cpu_wdata, mem_rdata, mem_busy,
        input  cpu_rdata, cpu_rdy, cpu_done,
               mem_ce, mem_write, mem_addr, mem_nbytes, mem_wdata
    );
endinterface

// File: rtl/cpu_mem_bridge.sv
// Single-outstanding 6502-to-PSRAM bridge with a local VIC colour-register window
// and a wait-state timeout that aborts hung memory transfers.
module cpu_mem_bridge #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd200
) (
    input  logic                  clkRAM,
    input  logic                  reset,
    cpu_mem_bridge_if.master      bus,
    output logic [3:0]            border_color,
    output logic [3:0]            bg_color,
    output logic                  timeout_err
);
    localparam int unsigned CNT_W = 8;
    localparam logic [15:0] ADDR_BORDER = 16'hD020;
    localparam logic [15:0] ADDR_BG     = 16'hD021;
    localparam logic [5:0]  VIC_PAGE    = 6'b110100;

    typedef enum logic [2:0] {
        IDLE,
        LOCAL,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             limit_hit;

    assign wait_cnt_next   = wait_cnt + CNT_W'(1);
    assign limit_hit       = (wait_cnt_next == TIMEOUT_CYCLES);
    assign bus.cpu_rdy     = (state == IDLE);
    assign bus.mem_nbytes  = 4'd1;

    // mem_addr/mem_write/mem_wdata double as the latched request for both paths.
    always_ff @(posedge clkRAM or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            bus.cpu_rdata <= 8'h00;
            bus.cpu_done  <= 1'b0;
            bus.mem_ce    <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= 16'h0000;
            bus.mem_wdata <= 8'h00;
            border_color  <= 4'hE;
            bg_color      <= 4'h6;
            timeout_err   <= 1'b0;
        end else begin
            bus.cpu_done <= 1'b0;
            bus.mem_ce   <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.cpu_valid) begin
                        bus.mem_addr  <= bus.cpu_addr;
                        bus.mem_write <= bus.cpu_we;
                        bus.mem_wdata <= bus.cpu_wdata;
                        wait_cnt      <= '0;
                        if (bus.cpu_addr[15:10] == VIC_PAGE) begin
                            state <= LOCAL;
                        end else begin
                            state      <= ISSUE;
                            bus.mem_ce <= 1'b1;
                        end
                    end
                end

                LOCAL: begin
                    state        <= IDLE;
                    bus.cpu_done <= 1'b1;
                    if (bus.mem_write) begin
                        if (bus.mem_addr == ADDR_BORDER) begin
                            border_color <= bus.mem_wdata[3:0];
                        end else if (bus.mem_addr == ADDR_BG) begin
                            bg_color <= bus.mem_wdata[3:0];
                        end
                    end else if (bus.mem_addr == ADDR_BORDER) begin
                        bus.cpu_rdata <= {4'hF, border_color};
                    end else if (bus.mem_addr == ADDR_BG) begin
                        bus.cpu_rdata <= {4'hF, bg_color};
                    end else begin
                        bus.cpu_rdata <= 8'hFF;
                    end
                end

                ISSUE: begin
                    state <= WAIT_ACK;
                end

                // A busy acknowledge does not count as completion, so the limit still aborts here.
                WAIT_ACK: begin
                    wait_cnt <= wait_cnt_next;
                    if (limit_hit) begin
                        state        <= IDLE;
                        bus.cpu_done <= 1'b1;
                        timeout_err  <= 1'b1;
                        if (!bus.mem_write) begin
                            bus.cpu_rdata <= 8'hFF;
                        end
                    end else if (bus.mem_busy) begin
                        state <= WAIT_DONE;
                    end
                end

                // Completion on the limit edge takes priority over the abort.
                WAIT_DONE: begin
                    wait_cnt <= wait_cnt_next;
                    if (!bus.mem_busy) begin
                        state        <= IDLE;
                        bus.cpu_done <= 1'b1;
                        if (!bus.mem_write) begin
                            bus.cpu_rdata <= bus.mem_rdata;
                        end
                    end else if (limit_hit) begin
                        state        <= IDLE;
                        bus.cpu_done <= 1'b1;
                        timeout_err  <= 1'b1;
                        if (!bus.mem_write) begin
                            bus.cpu_rdata <= 8'hFF;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed plus randomized bench for cpu_mem_bridge against a transaction-level
// model of the colour registers, RAM contents, read-data holding and timeout rules.
module tb_cpu_mem_bridge;
    localparam int unsigned T = 12;

    logic       clkRAM = 1'b0;
    logic       reset  = 1'b0;
    logic [3:0] border_color;
    logic [3:0] bg_color;
    logic       timeout_err;

    always #5 clkRAM = ~clkRAM;

    cpu_mem_bridge_if bus ();

    cpu_mem_bridge #(.TIMEOUT_CYCLES(8'(T))) dut (
        .clkRAM       (clkRAM),
        .reset        (reset),
        .bus          (bus),
        .border_color (border_color),
        .bg_color     (bg_color),
        .timeout_err  (timeout_err)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference state: what the CPU should see after each completed access.
    logic [3:0] m_border = 4'hE;
    logic [3:0] m_bg     = 4'h6;
    logic [7:0] m_rdata  = 8'h00;
    logic       m_terr   = 1'b0;
    logic [7:0] ref_ram [logic [15:0]];
    logic [7:0] dev_ram [logic [15:0]];

    // Memory-controller behaviour knobs.
    int rsp_len    = 1;
    bit rsp_stuck  = 1'b0;
    bit rsp_active = 1'b0;

    function automatic logic [7:0] dflt(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_ram.exists(a) ? ref_ram[a] : dflt(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory controller: busy from the edge after the strobe for rsp_len edges.
    initial begin
        logic [15:0] ra;
        logic        rw;
        logic [7:0]  rd;
        bus.mem_busy  = 1'b0;
        bus.mem_rdata = 8'h00;
        forever begin
            @(negedge clkRAM);
            if (bus.mem_ce === 1'b1 && !rsp_stuck) begin
                rsp_active = 1'b1;
                ra = bus.mem_addr;
                rw = bus.mem_write;
                rd = bus.mem_wdata;
                @(posedge clkRAM);
                #1 bus.mem_busy = 1'b1;
                bus.mem_rdata = $urandom_range(0, 255);
                repeat (rsp_len) @(posedge clkRAM);
                #1;
                if (rw) dev_ram[ra] = rd;
                else    bus.mem_rdata = dev_ram.exists(ra) ? dev_ram[ra] : dflt(ra);
                bus.mem_busy = 1'b0;
                rsp_active = 1'b0;
            end
        end
    end

    // One CPU access, starting at a negedge with the bridge idle; ends on the done sample.
    task automatic txn(input string tag, input logic [15:0] a, input bit we,
                       input logic [7:0] wd, input int len, input bit stuck, input bit hold);
        bit is_local;
        bit abort;
        int exp_done;
        int done_at;
        int ce_cnt;
        bit ce_first;
        bit rdy_bad;
        is_local = (a >= 16'hD000) && (a <= 16'hD3FF);
        abort    = !is_local && (stuck || len >= int'(T));
        exp_done = is_local ? 1 : (abort ? int'(T) + 1 : len + 2);

        if (is_local) begin
            if (we) begin
                if (a == 16'hD020)      m_border = wd[3:0];
                else if (a == 16'hD021) m_bg     = wd[3:0];
            end else begin
                m_rdata = (a == 16'hD020) ? {4'hF, m_border} :
                          (a == 16'hD021) ? {4'hF, m_bg} : 8'hFF;
            end
        end else if (abort) begin
            m_terr = 1'b1;
            if (!we) m_rdata = 8'hFF;
        end else if (we) begin
            ref_ram[a] = wd;
        end else begin
            m_rdata = ref_rd(a);
        end

        rsp_len   = len;
        rsp_stuck = stuck;
        bus.cpu_addr  = a;
        bus.cpu_we    = we;
        bus.cpu_wdata = wd;
        bus.cpu_valid = 1'b1;
        @(posedge clkRAM);
        done_at = -1; ce_cnt = 0; ce_first = 1'b0; rdy_bad = 1'b0;
        for (int i = 0; i < int'(T) + 10 && done_at < 0; i++) begin
            @(negedge clkRAM);
            if (i == 0 && !hold) bus.cpu_valid = 1'b0;
            if (i == 0) ce_first = bus.mem_ce;
            if (bus.mem_ce === 1'b1) ce_cnt++;
            if (bus.cpu_done === 1'b1) done_at = i;
            else if (bus.cpu_rdy !== 1'b0) rdy_bad = 1'b1;
        end

        chk({tag, ".latency"}, 32'(done_at), 32'(exp_done));
        chk({tag, ".rdy_low"}, 32'(rdy_bad), 32'd0);
        chk({tag, ".rdy_back"}, 32'(bus.cpu_rdy), 32'd1);
        chk({tag, ".ce_count"}, 32'(ce_cnt), is_local ? 32'd0 : 32'd1);
        chk({tag, ".rdata"}, 32'(bus.cpu_rdata), 32'(m_rdata));
        chk({tag, ".terr"}, 32'(timeout_err), 32'(m_terr));
        chk({tag, ".colors"}, 32'({border_color, bg_color}), 32'({m_border, m_bg}));
        if (!is_local) begin
            chk({tag, ".ce_first"}, 32'(ce_first), 32'd1);
            chk({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(a));
            chk({tag, ".mem_write"}, 32'(bus.mem_write), 32'(we));
            if (we) chk({tag, ".mem_wdata"}, 32'(bus.mem_wdata), 32'(wd));
        end
        rsp_stuck = 1'b0;
    endtask

    task automatic wait_mem_idle(input string tag);
        for (int k = 0; k < 60 && rsp_active; k++) @(negedge clkRAM);
        chk({tag, ".mem_idle"}, 32'(rsp_active), 32'd0);
    endtask

    initial begin
        bit saw_done;
        logic [15:0] a;
        int sel;
        bus.cpu_valid = 1'b0;
        bus.cpu_addr  = 16'h0000;
        bus.cpu_we    = 1'b0;
        bus.cpu_wdata = 8'h00;

        // Reset defaults, observed while reset is held and after release.
        repeat (3) @(negedge clkRAM);
        chk("rst.rdy", 32'(bus.cpu_rdy), 32'd1);
        chk("rst.ce", 32'(bus.mem_ce), 32'd0);
        reset = 1'b1;
        @(negedge clkRAM);
        chk("rst.colors", 32'({border_color, bg_color}), 32'h0000_00E6);
        chk("rst.terr", 32'(timeout_err), 32'd0);
        chk("rst.done_ce_wr", 32'({bus.cpu_done, bus.mem_ce, bus.mem_write}), 32'd0);
        chk("rst.addr", 32'(bus.mem_addr), 32'h0000);
        chk("rst.data", 32'({bus.mem_wdata, bus.cpu_rdata}), 32'h0000);
        chk("rst.rdy2", 32'(bus.cpu_rdy), 32'd1);
        chk("nbytes", 32'(bus.mem_nbytes), 32'd1);

        // Local colour registers and the rest of the window.
        txn("loc_wr_d020", 16'hD020, 1'b1, 8'h25, 1, 1'b0, 1'b0);
        txn("loc_rd_d020", 16'hD020, 1'b0, 8'h00, 1, 1'b0, 1'b0);
        txn("loc_wr_d021", 16'hD021, 1'b1, 8'h3C, 1, 1'b0, 1'b0);
        txn("loc_rd_d021", 16'hD021, 1'b0, 8'h00, 1, 1'b0, 1'b0);
        txn("loc_wr_d100", 16'hD100, 1'b1, 8'h77, 1, 1'b0, 1'b0);
        txn("loc_rd_d3ff", 16'hD3FF, 1'b0, 8'h00, 1, 1'b0, 1'b0);
        txn("loc_wr_d000", 16'hD000, 1'b1, 8'h11, 1, 1'b0, 1'b0);

        // RAM read with preloaded contents and 3 busy cycles; window edges are RAM.
        ref_ram[16'hC000] = 8'h8D;
        dev_ram[16'hC000] = 8'h8D;
        @(negedge clkRAM);
        txn("ram_rd_c000", 16'hC000, 1'b0, 8'h00, 3, 1'b0, 1'b0);
        txn("ram_rd_cfff", 16'hCFFF, 1'b0, 8'h00, 1, 1'b0, 1'b0);
        txn("ram_rd_d400", 16'hD400, 1'b0, 8'h00, 2, 1'b0, 1'b0);

        // Back-to-back with cpu_valid held high across the first access.
        txn("b2b_wr_1234", 16'h1234, 1'b1, 8'hA5, 2, 1'b0, 1'b1);
        txn("b2b_rd_1234", 16'h1234, 1'b0, 8'h00, 1, 1'b0, 1'b0);

        // Completion exactly on the limit edge beats the timeout.
        txn("lim_rd", 16'h2000, 1'b0, 8'h00, int'(T) - 1, 1'b0, 1'b0);
        txn("lim_wr", 16'h2001, 1'b1, 8'h5E, int'(T) - 1, 1'b0, 1'b0);

        // Memory never acknowledges, then a good access keeps the sticky flag.
        txn("to_stuck", 16'h0800, 1'b0, 8'h00, 1, 1'b1, 1'b0);
        txn("to_after", 16'hC000, 1'b0, 8'h00, 2, 1'b0, 1'b0);
        txn("to_stuck_wr", 16'h0900, 1'b1, 8'h42, 1, 1'b1, 1'b0);
        // Memory stays busy past the limit inside WAIT_DONE.
        txn("to_busy", 16'h3000, 1'b0, 8'h00, int'(T) + 2, 1'b0, 1'b0);
        wait_mem_idle("to_busy");

        // Reset while the bridge sits in WAIT_DONE.
        @(negedge clkRAM);
        rsp_len = 8;
        bus.cpu_addr  = 16'h4000;
        bus.cpu_we    = 1'b0;
        bus.cpu_valid = 1'b1;
        @(posedge clkRAM);
        @(negedge clkRAM);
        bus.cpu_valid = 1'b0;
        repeat (2) @(negedge clkRAM);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst.rdy", 32'(bus.cpu_rdy), 32'd1);
        chk("mid_rst.ce_done", 32'({bus.mem_ce, bus.cpu_done}), 32'd0);
        chk("mid_rst.border", 32'(border_color), 32'hE);
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clkRAM);
            if (bus.cpu_done === 1'b1) saw_done = 1'b1;
        end
        chk("mid_rst.no_done", 32'(saw_done), 32'd0);
        wait_mem_idle("mid_rst");
        reset = 1'b1;
        m_border = 4'hE; m_bg = 4'h6; m_rdata = 8'h00; m_terr = 1'b0;
        @(negedge clkRAM);
        chk("mid_rst.terr", 32'(timeout_err), 32'd0);
        txn("post_rst", 16'h4000, 1'b0, 8'h00, 1, 1'b0, 1'b0);

        // Randomized mix of local and RAM accesses.
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 7));
            case (sel)
                0: a = 16'hD020;
                1: a = 16'hD021;
                2: a = 16'hD000 + 16'($urandom_range(0, 16'h3FF));
                3: a = 16'hD3FF;
                4: a = 16'hCFFF;
                5: a = 16'hD400;
                default: begin
                    a = 16'($urandom);
                    if (a[15:10] == 6'b110100) a[12] = 1'b0;
                end
            endcase
            txn($sformatf("rnd%0d", n), a, 1'($urandom), 8'($urandom),
                int'($urandom_range(1, 6)), 1'b0, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
